// File: rtl/overlap_accum_seq.sv
// ---------------------------------------------------------------------------
// overlap_accum_seq
//
// Sequential overlap combiner for the OBS GF(2) multiplier tree. The four
// (N-1)-bit sub-products arrive one at a time on a valid/ready stream. Each
// beat carries a slot index. Each beat is XOR-accumulated into its interleaved
// position of a (2N-1)-bit accumulator. When all four slots of a set have
// been seen, the combined word is presented on a valid/ready output.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   clr       synchronous abort/clear of the current set and the error flag
//   s_valid   input beat valid
//   s_ready   input beat accepted when s_valid & s_ready
//   s_sel     slot index of the beat (0..3 -> in1..in4)
//   s_data    sub-product bits, N-1 wide
//   m_valid   combined result valid
//   m_ready   downstream accepts result
//   m_data    combined result, 2N-1 wide (zero while collecting)
//   busy      a set is partly collected or a result is waiting
//   err       sticky flag: a slot was delivered twice within one set
//   done_cnt  number of results handed off, wrapping
// ---------------------------------------------------------------------------
module overlap_accum_seq #(
  parameter int N     = 12,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [1:0]         s_sel,
  input  logic [N-2:0]       s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [2*N-2:0]     m_data,
  output logic               busy,
  output logic               err,
  output logic [CNT_W-1:0]   done_cnt
);

  localparam int AW = 2*N - 1;

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t             r_state, w_nextState;
  logic [AW-1:0]      r_acc, w_accNext;
  logic [AW-1:0]      r_mdata;
  logic [AW-1:0]      w_place;
  logic [3:0]         r_mask, w_maskNext;
  logic [3:0]         w_selBit;
  logic               r_err, w_errNext;
  logic [CNT_W-1:0]   r_cnt, w_cntNext;
  logic               w_accept;

  // Spread the beat onto the accumulator grid. Slots 1 and 2 both land on
  // the odd positions. Slot 0 lands on the even positions. Slot 3 lands on
  // the even positions shifted up by one pair.
  always_comb begin
    w_place = '0;
    for (int i = 0; i < N-1; i++) begin
      case (s_sel)
        2'd0:       w_place[2*i]   = s_data[i];
        2'd1, 2'd2: w_place[2*i+1] = s_data[i];
        default:    w_place[2*i+2] = s_data[i];
      endcase
    end
  end

  assign w_selBit = 4'b0001 << s_sel;
  assign s_ready  = (r_state == COLLECT);
  assign w_accept = s_valid & s_ready;

  // Next-state logic. clr overrides everything. It discards any beat and any
  // handshake presented in the same cycle. It also leaves the counter alone.
  always_comb begin
    w_nextState = r_state;
    w_accNext   = r_acc;
    w_maskNext  = r_mask;
    w_errNext   = r_err;
    w_cntNext   = r_cnt;
    if (clr) begin
      w_nextState = COLLECT;
      w_accNext   = '0;
      w_maskNext  = '0;
      w_errNext   = 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_accept) begin
            if ((r_mask & w_selBit) != 4'b0000) begin
              // A repeated slot is handshaken but has no effect on the set.
              w_errNext = 1'b1;
            end else begin
              w_accNext  = r_acc ^ w_place;
              w_maskNext = r_mask | w_selBit;
              if ((r_mask | w_selBit) == 4'b1111) begin
                w_nextState = HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (m_ready) begin
            w_nextState = COLLECT;
            w_accNext   = '0;
            w_maskNext  = '0;
            w_cntNext   = r_cnt + 1'b1;
          end
        end
        default: begin
          w_nextState = COLLECT;
        end
      endcase
    end
  end

  // State registers. m_data shadows the accumulator only while a result is
  // held, so downstream sees zero during collection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= COLLECT;
      r_acc   <= '0;
      r_mask  <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_mdata <= '0;
    end else begin
      r_state <= w_nextState;
      r_acc   <= w_accNext;
      r_mask  <= w_maskNext;
      r_err   <= w_errNext;
      r_cnt   <= w_cntNext;
      r_mdata <= (w_nextState == HOLD) ? w_accNext : '0;
    end
  end

  assign m_valid  = (r_state == HOLD);
  assign m_data   = r_mdata;
  assign busy     = (r_mask != 4'b0000) | (r_state == HOLD);
  assign err      = r_err;
  assign done_cnt = r_cnt;

endmodule

// File: tb/tb_overlap_accum_seq.sv
// ---------------------------------------------------------------------------
// tb_overlap_accum_seq
//
// Scoreboard bench for overlap_accum_seq with N=12 and a 2-bit result
// counter, so that the counter wrap is exercised. A reference model tracks
// the slots delivered. When a set completes, the model pushes the expected
// combined word, which is derived from the per-bit sum equations. The result
// is popped when the DUT hands it off.
// ---------------------------------------------------------------------------
module tb_overlap_accum_seq;

  localparam int N     = 12;
  localparam int CNT_W = 2;
  localparam int AW    = 2*N - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr;
  logic              s_valid;
  logic              s_ready;
  logic [1:0]        s_sel;
  logic [N-2:0]      s_data;
  logic              m_valid;
  logic              m_ready;
  logic [AW-1:0]     m_data;
  logic              busy;
  logic              err;
  logic [CNT_W-1:0]  done_cnt;

  int checkCount = 0;
  int passCount  = 0;

  logic [N-2:0]      modIn [4];
  logic [3:0]        modMask;
  logic              modErr;
  logic [CNT_W-1:0]  modCnt;
  logic [AW-1:0]     expQ [$];

  overlap_accum_seq #(.N(N), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_sel    (s_sel),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .busy     (busy),
    .err      (err),
    .done_cnt (done_cnt)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Safety net so a stuck design can never hang the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checkCount++;
    if (obs !== expv)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    else
      passCount++;
  endtask

  // Expected combined word, built from the per-bit sum equations.
  function automatic logic [AW-1:0] expectedResult();
    logic [AW-1:0] r;
    r = '0;
    r[0]    = modIn[0][0];
    r[AW-1] = modIn[3][N-2];
    for (int k = 1; k <= N-2; k++) r[2*k]   = modIn[0][k] ^ modIn[3][k-1];
    for (int k = 0; k <= N-2; k++) r[2*k+1] = modIn[1][k] ^ modIn[2][k];
    return r;
  endfunction

  task automatic modelClear();
    modMask = '0;
    for (int i = 0; i < 4; i++) modIn[i] = '0;
  endtask

  task automatic modelBeat(input logic [1:0] sel, input logic [N-2:0] data);
    if (modMask[sel]) begin
      modErr = 1'b1;
    end else begin
      modIn[sel]   = data;
      modMask[sel] = 1'b1;
      if (modMask == 4'hF) begin
        expQ.push_back(expectedResult());
        modelClear();
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present one beat and hold it until it is accepted. The task is entered
  // and left #1 after a rising edge.
  task automatic applyStimulus(input logic [1:0] sel, input logic [N-2:0] data);
    bit accepted;
    accepted = 0;
    s_valid = 1'b1;
    s_sel   = sel;
    s_data  = data;
    for (int t = 0; t < 20 && !accepted; t++) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk); #1;
        accepted = 1;
      end
    end
    s_valid = 1'b0;
    s_sel   = 2'($urandom);
    s_data  = (N-1)'($urandom);
    if (!accepted) checkOutput("beat_accept_timeout", 0, 1);
    else modelBeat(sel, data);
  endtask

  // Wait for a result, stall it for holdCycles cycles, then accept it and
  // compare it against the scoreboard.
  task automatic collectResult(input int holdCycles, input bit checkLatency);
    bit seen;
    int waited;
    logic [AW-1:0] expv;
    seen = 0;
    waited = 0;
    m_ready = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (m_valid) seen = 1; else waited++;
    end
    if (!seen) begin
      checkOutput("m_valid_timeout", 0, 1);
      @(posedge clk); #1;
      return;
    end
    if (checkLatency) checkOutput("m_valid_latency", waited, 0);
    if (expQ.size() == 0) begin
      checkOutput("scoreboard_empty", 0, 1);
      @(posedge clk); #1;
      return;
    end
    expv = expQ.pop_front();
    checkOutput("m_data", m_data, expv);
    checkOutput("s_ready_hold", s_ready, 0);
    checkOutput("busy_hold", busy, 1);
    repeat (holdCycles) begin
      @(negedge clk);
      checkOutput("m_valid_stall", m_valid, 1);
      checkOutput("m_data_stable", m_data, expv);
      checkOutput("s_ready_stall", s_ready, 0);
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    modCnt = modCnt + 1'b1;
    @(negedge clk);
    checkOutput("m_valid_after", m_valid, 0);
    checkOutput("s_ready_after", s_ready, 1);
    checkOutput("m_data_after", m_data, 0);
    checkOutput("busy_after", busy, 0);
    checkOutput("done_cnt", done_cnt, modCnt);
    @(posedge clk); #1;
  endtask

  task automatic checkErr();
    @(negedge clk);
    checkOutput("err", err, modErr);
    @(posedge clk); #1;
  endtask

  // Pulse clr, optionally with a beat presented at the same time.
  task automatic clearPulse(input bit withBeat, input logic [1:0] sel, input logic [N-2:0] data);
    clr     = 1'b1;
    s_valid = withBeat;
    s_sel   = sel;
    s_data  = data;
    @(posedge clk); #1;
    clr     = 1'b0;
    s_valid = 1'b0;
    modelClear();
    modErr = 1'b0;
    @(negedge clk);
    checkOutput("clr_err", err, 0);
    checkOutput("clr_busy", busy, 0);
    checkOutput("clr_m_valid", m_valid, 0);
    checkOutput("clr_m_data", m_data, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int order[4];
    int tmp;
    int j;
    rst_n   = 1'b0;
    clr     = 1'b0;
    s_valid = 1'b0;
    s_sel   = '0;
    s_data  = '0;
    m_ready = 1'b0;
    modErr  = 1'b0;
    modCnt  = '0;
    modelClear();

    #12;
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_data", m_data, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done_cnt", done_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_s_ready", s_ready, 1);

    // Slot 0 alone, back to back: even positions 0..20.
    applyStimulus(2'd0, 11'h7FF);
    applyStimulus(2'd1, 11'h000);
    applyStimulus(2'd2, 11'h000);
    applyStimulus(2'd3, 11'h000);
    checkOutput("model_set1", expQ[0], 23'h155555);
    collectResult(0, 1);

    // All ones, out of order with gaps: odd positions cancel.
    applyStimulus(2'd3, 11'h7FF); idle($urandom_range(0, 3));
    applyStimulus(2'd1, 11'h7FF); idle($urandom_range(0, 3));
    applyStimulus(2'd0, 11'h7FF); idle($urandom_range(0, 3));
    applyStimulus(2'd2, 11'h7FF);
    collectResult(0, 1);

    // Slot 1 alone with a five-cycle downstream stall.
    applyStimulus(2'd1, 11'h7FF);
    applyStimulus(2'd0, 11'h000);
    applyStimulus(2'd2, 11'h000);
    applyStimulus(2'd3, 11'h000);
    collectResult(5, 1);

    // Duplicate slot 0 is dropped and flags err until cleared.
    applyStimulus(2'd0, 11'h001);
    applyStimulus(2'd0, 11'h7FF);
    checkErr();
    applyStimulus(2'd1, 11'h000);
    applyStimulus(2'd2, 11'h000);
    applyStimulus(2'd3, 11'h000);
    collectResult(0, 1);
    checkErr();
    clearPulse(1'b0, 2'd0, 11'h000);

    // Abort a partial set; the beat presented with clr must be discarded.
    applyStimulus(2'd0, 11'h7FF);
    applyStimulus(2'd1, 11'h555);
    clearPulse(1'b1, 2'd2, 11'h123);
    applyStimulus(2'd3, 11'h7FF);
    applyStimulus(2'd0, 11'h000);
    applyStimulus(2'd1, 11'h000);
    applyStimulus(2'd2, 11'h000);
    checkErr();
    checkOutput("model_set5", expQ[0], 23'h555554);
    collectResult(0, 1);

    // Random sets in random order, walking the counter through its wrap.
    for (int s = 0; s < 5; s++) begin
      for (int i = 0; i < 4; i++) order[i] = i;
      for (int i = 3; i > 0; i--) begin
        j = $urandom_range(0, i);
        tmp = order[i]; order[i] = order[j]; order[j] = tmp;
      end
      for (int i = 0; i < 4; i++) begin
        applyStimulus(2'(order[i]), (N-1)'($urandom));
        idle($urandom_range(0, 2));
      end
      collectResult($urandom_range(0, 2), 0);
    end

    // Reset mid-set: everything returns to zero at once.
    applyStimulus(2'd0, 11'h3A5);
    applyStimulus(2'd0, 11'h0F0);
    applyStimulus(2'd1, 11'h1C3);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_m_valid", m_valid, 0);
    checkOutput("mid_rst_m_data", m_data, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_err", err, 0);
    checkOutput("mid_rst_done_cnt", done_cnt, 0);
    @(negedge clk);
    checkOutput("mid_rst_no_valid", m_valid, 0);
    rst_n = 1'b1;
    modelClear();
    modErr = 1'b0;
    modCnt = '0;
    expQ.delete();
    @(posedge clk); #1;

    // A full set after reset works and counts from zero.
    applyStimulus(2'd2, 11'h2B6);
    applyStimulus(2'd3, 11'h4C1);
    applyStimulus(2'd1, 11'h13F);
    applyStimulus(2'd0, 11'h6E2);
    collectResult(1, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/overlap_accum_seq.md
Name: overlap_accum_seq

Overview:
- Sequential, parametrised successor to the fixed 12-bit four-input overlap combiner used in the OBS GF(2) multiplier tree.
- Accepts the four (N-1)-bit sub-products one beat at a time over a valid/ready stream, each beat tagged with its slot index.
- XOR-accumulates each beat into its interleaved position of a (2N-1)-bit register and presents the finished result on a valid/ready output.
- Lets one narrow bus and one combiner serve several multiplier levels. Adds duplicate-slot error detection, abort, and a completed-result counter.

Parameters:
N  12  sub-multiplier size; sub-product width N-1, result width 2N-1 (N >= 3)
CNT_W  8  width of completed-result counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous abort/clear, highest priority after reset
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid & s_ready
s_sel  in  2  slot index: 0=in1, 1=in2, 2=in3, 3=in4
s_data  in  N-1  sub-product bits
m_valid  out  1  result valid
m_ready  in  1  downstream accepts result
m_data  out  2N-1  combined result
busy  out  1  collection in progress or result pending
err  out  1  sticky duplicate-slot flag
done_cnt  out  CNT_W  number of results handed off, wraps

Behaviour:
- Reset (rst_n=0, asynchronous):
  - acc=0, mask=0, state=COLLECT.
  - m_valid=0, m_data=0, err=0, done_cnt=0, busy=0, s_ready=1 after release.
- Placement rule, for i in 0..N-2:
  - sel0 bit i -> acc[2i]
  - sel1 bit i -> acc[2i+1]
  - sel2 bit i -> acc[2i+1]
  - sel3 bit i -> acc[2i+2]
  - Every accepted beat XORs its placed vector into acc; no other bits change.
- Resulting sums:
  - acc[0] = in1[0]
  - acc[2N-2] = in4[N-2]
  - even 2k (1<=k<=N-2) = in1[k]^in4[k-1]
  - odd 2k+1 = in2[k]^in3[k]
- mask[3:0] records the slots accepted for the current set.
- State COLLECT:
  - s_ready=1, m_valid=0.
  - Accepted beat with mask[s_sel]=0: acc updated, mask bit set.
  - Accepted beat with mask[s_sel]=1: beat dropped (acc and mask unchanged), err set sticky. The beat is still handshaken.
  - If an accepted beat makes mask==4'b1111, next state is HOLD. m_valid=1 in the following cycle, one cycle latency from the last beat.
  - Beats may arrive in any slot order, with any idle gaps.
- State HOLD:
  - s_ready=0, m_valid=1, m_data=acc, held stable until handshake.
  - On m_valid & m_ready: done_cnt increments (wraps at 2^CNT_W-1 -> 0), acc=0, mask=0, next state COLLECT.
  - m_valid drops next cycle and s_ready rises next cycle; no same-cycle pass-through.
- m_data is a registered copy of acc, 0 in COLLECT.
- busy = (mask != 0) | (state == HOLD).
- clr=1 in any state, including mid-set or while HOLD with m_ready=1:
  - Next cycle acc=0, mask=0, err=0, m_valid=0, state=COLLECT.
  - done_cnt unchanged; no handshake counted that cycle.
  - An input beat presented with clr is discarded.
- Reset asserted mid-operation: immediate return to reset values, no partial result emitted.
- s_sel and s_data are ignored when s_valid=0. X on s_data is ignored when the beat is not accepted.

Test Plan:
- N=12: beats sel0=0x7FF, sel1=0, sel2=0, sel3=0, back-to-back, m_ready=1 -> m_valid one cycle after 4th beat, m_data=0x155555, done_cnt=1, busy low after handoff.
- N=12, order sel3,sel1,sel0,sel2 with data 0x7FF,0x7FF,0x7FF,0x7FF, random gaps -> m_data=0x400001 (odd bits cancel, only bit0 and bit22 set).
- sel1=0x7FF, others 0; m_ready held low 5 cycles -> m_data=0x2AAAAA stable, m_valid=1, s_ready=0 throughout; handshake on 6th cycle -> done_cnt=1.
- sel0=0x001, then sel0=0x7FF (duplicate), then sel1/2/3=0 -> err=1, m_data=0x000001 (duplicate dropped); clr next cycle -> err=0, mask=0.
- Two beats accepted, then clr with s_valid=1 sel2=0x123 -> acc=0, state COLLECT, sel2 beat not recorded; full new set of 0x7FF in sel3 only -> m_data=0x555554.
- CNT_W=2, five complete sets -> done_cnt sequence 1,2,3,0,1. rst_n pulsed low mid-set -> all outputs zero immediately, no m_valid.
